// File: rtl/onchip_ram_pkg.sv
// Shared definitions for the onchip_dp_ram_avmm RAM:
//   - state_e      : controller state (clear engine running / normal service)
//   - RL_ONE/RL_TWO: the two supported read latencies
//   - byte_parity  : even-parity bit for one byte lane
package onchip_ram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int RL_ONE = 1;
   localparam int RL_TWO = 2;

   // Stored bit makes the total number of ones in {parity, byte} even.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// True-dual-port storage array with per-lane write enables and a registered
// read on each port. A read and a write to the same word in the same cycle
// return the old contents.
// Ports:
//   clk                     sole clock
//   a_re / b_re             read enable (captures the word into *_rdata)
//   a_we / b_we [LANES]     per-lane write enables
//   a_idx / b_idx [IDX_W]   word index
//   a_wdata / b_wdata       write lanes
//   a_rdata / b_rdata       registered read lanes (held while *_re is low)
// The two ports are never asked to write the same word in one cycle.
module onchip_ram_core #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int IDX_W  = 11,
   parameter int DEPTH  = 2048
) (
   input  logic                          clk,
   input  logic                          a_re,
   input  logic [LANES-1:0]              a_we,
   input  logic [IDX_W-1:0]              a_idx,
   input  logic [LANES-1:0][LANE_W-1:0]  a_wdata,
   output logic [LANES-1:0][LANE_W-1:0]  a_rdata,
   input  logic                          b_re,
   input  logic [LANES-1:0]              b_we,
   input  logic [IDX_W-1:0]              b_idx,
   input  logic [LANES-1:0][LANE_W-1:0]  b_wdata,
   output logic [LANES-1:0][LANE_W-1:0]  b_rdata
);

   logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

   // NOTE: the array and its read registers carry no reset so they map onto
   // block RAM; contents are defined by the clear engine or by writes.
   always_ff @(posedge clk) begin
      if (a_re) a_rdata <= mem[a_idx];
      if (b_re) b_rdata <= mem[b_idx];
      for (int l = 0; l < LANES; l++) begin
         if (a_we[l]) mem[a_idx][l] <= a_wdata[l];
         if (b_we[l]) mem[b_idx][l] <= b_wdata[l];
      end
   end

endmodule

// File: rtl/onchip_dp_ram_avmm.sv
// Dual-port on-chip RAM with two Avalon-MM pipelined slave ports (s1, s2).
// Holds the clear engine FSM, the same-address write arbiter (s1 wins, s2
// is stalled one cycle), the read-latency pipes and the parity check.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   sN_address/chipselect/read/write/byteenable/writedata   request
//   sN_readdata/readdatavalid    response, READ_LATENCY cycles after accept
//   sN_waitrequest               request not accepted this cycle
//   init_done                    clear engine finished (level)
//   sN_parity_err                parity mismatch, aligned with readdatavalid
// Build option: define ONCHIP_RAM_PARITY_EN to store one even-parity bit per
// byte; otherwise sN_parity_err is tied to 0.
module onchip_dp_ram_avmm
   import onchip_ram_pkg::*;
#(
   parameter int              DATA_W        = 32,
   parameter int              ADDR_W        = 11,
   parameter int              DEPTH         = 2048,
   parameter int              READ_LATENCY  = 1,
   parameter int              INIT_ON_RESET = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     s1_address,
   input  logic                  s1_chipselect,
   input  logic                  s1_read,
   input  logic                  s1_write,
   input  logic [DATA_W/8-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]     s1_writedata,
   output logic [DATA_W-1:0]     s1_readdata,
   output logic                  s1_readdatavalid,
   output logic                  s1_waitrequest,
   output logic                  s1_parity_err,
   input  logic [ADDR_W-1:0]     s2_address,
   input  logic                  s2_chipselect,
   input  logic                  s2_read,
   input  logic                  s2_write,
   input  logic [DATA_W/8-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]     s2_writedata,
   output logic [DATA_W-1:0]     s2_readdata,
   output logic                  s2_readdatavalid,
   output logic                  s2_waitrequest,
   output logic                  s2_parity_err,
   output logic                  init_done
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ONCHIP_RAM_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif

   typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

   function automatic lanes_t pack_lanes(input logic [DATA_W-1:0] d);
      lanes_t r;
      for (int l = 0; l < LANES; l++) begin
`ifdef ONCHIP_RAM_PARITY_EN
         r[l] = {byte_parity(d[8*l +: 8]), d[8*l +: 8]};
`else
         r[l] = d[8*l +: 8];
`endif
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] unpack_data(input lanes_t r);
      logic [DATA_W-1:0] d;
      for (int l = 0; l < LANES; l++) d[8*l +: 8] = r[l][7:0];
      return d;
   endfunction

   // Port 0 is s1, port 1 is s2.
   logic              cs    [2];
   logic              rd    [2];
   logic              wr    [2];
   logic [ADDR_W-1:0] addr  [2];
   logic [LANES-1:0]  be    [2];
   logic [DATA_W-1:0] wdata [2];

   assign cs[0] = s1_chipselect;  assign cs[1] = s2_chipselect;
   assign rd[0] = s1_read;        assign rd[1] = s2_read;
   assign wr[0] = s1_write;       assign wr[1] = s2_write;
   assign addr[0] = s1_address;   assign addr[1] = s2_address;
   assign be[0] = s1_byteenable;  assign be[1] = s2_byteenable;
   assign wdata[0] = s1_writedata; assign wdata[1] = s2_writedata;

   // ---------------- clear engine FSM ----------------
   state_e           state_q;
   logic [IDX_W-1:0] clr_cnt_q;
   logic             live_q;       // low until the first edge after reset
   logic             init_done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         clr_cnt_q   <= '0;
         live_q      <= 1'b0;
         init_done_q <= (INIT_ON_RESET == 0);
      end else begin
         live_q <= 1'b1;
         case (state_q)
            ST_INIT: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign init_done = init_done_q;

   // ---------------- accept / arbitration ----------------
   logic accept_ok, s1_wr_acc;
   logic wait_req [2];
   logic do_rd    [2];
   logic do_wr    [2];
   logic in_rng   [2];

   // NOTE: combinational blocks assign every output first and use blocking
   // assignments, so no latch is inferred and later lines see updated values.
   always_comb begin
      accept_ok   = live_q && (state_q == ST_RUN);
      s1_wr_acc   = accept_ok && s1_chipselect && s1_write;
      wait_req[0] = !accept_ok;
      // Same-word write collision: s1 proceeds, s2 retries next cycle.
      wait_req[1] = !accept_ok ||
                    (s1_wr_acc && s2_chipselect && s2_write && (s1_address == s2_address));
      for (int p = 0; p < 2; p++) begin
         in_rng[p] = ({1'b0, addr[p]} < (ADDR_W + 1)'(DEPTH));
         do_wr[p]  = cs[p] && wr[p] && !wait_req[p];
         do_rd[p]  = cs[p] && rd[p] && !wr[p] && !wait_req[p];
      end
   end

   assign s1_waitrequest = wait_req[0];
   assign s2_waitrequest = wait_req[1];

   // ---------------- array ----------------
   logic             a_re, b_re;
   logic [LANES-1:0] a_we, b_we;
   logic [IDX_W-1:0] a_idx, b_idx;
   lanes_t           a_wd, b_wd;
   lanes_t           core_rd [2];

   always_comb begin
      a_re  = do_rd[0] && in_rng[0];
      a_we  = (do_wr[0] && in_rng[0]) ? be[0] : '0;
      a_idx = addr[0][IDX_W-1:0];
      a_wd  = pack_lanes(wdata[0]);
      // The clear engine owns port a while initialising; no requests are
      // accepted then, so nothing is displaced.
      if (state_q == ST_INIT) begin
         a_we  = '1;
         a_idx = clr_cnt_q;
         a_wd  = pack_lanes(INIT_VALUE);
      end
      b_re  = do_rd[1] && in_rng[1];
      b_we  = (do_wr[1] && in_rng[1]) ? be[1] : '0;
      b_idx = addr[1][IDX_W-1:0];
      b_wd  = pack_lanes(wdata[1]);
   end

   onchip_ram_core #(
      .LANES (LANES),
      .LANE_W(LANE_W),
      .IDX_W (IDX_W),
      .DEPTH (DEPTH)
   ) u_core (
      .clk    (clk),
      .a_re   (a_re),
      .a_we   (a_we),
      .a_idx  (a_idx),
      .a_wdata(a_wd),
      .a_rdata(core_rd[0]),
      .b_re   (b_re),
      .b_we   (b_we),
      .b_idx  (b_idx),
      .b_wdata(b_wd),
      .b_rdata(core_rd[1])
   );

   // ---------------- read response pipes ----------------
   logic              rdv_o  [2];
   logic [DATA_W-1:0] rdata_o[2];
   logic              perr_o [2];

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic              vld1_q, vld1_d, oob1_q, oob1_d;
      lanes_t            p1_lanes, out_raw;
      logic              out_vld;
      logic [DATA_W-1:0] hold_q, hold_d;

      always_comb begin
         vld1_d   = do_rd[p];
         oob1_d   = !in_rng[p];
         // Out-of-range reads return zero (with consistent parity).
         p1_lanes = oob1_q ? '0 : core_rd[p];
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            vld1_q <= 1'b0;
            oob1_q <= 1'b0;
         end else begin
            vld1_q <= vld1_d;
            oob1_q <= oob1_d;
         end
      end

      if (READ_LATENCY == RL_TWO) begin : g_rl2
         logic   vld2_q, vld2_d;
         lanes_t dat2_q, dat2_d;

         always_comb begin
            vld2_d = vld1_q;
            dat2_d = vld1_q ? p1_lanes : dat2_q;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld2_q <= 1'b0;
               dat2_q <= '0;
            end else begin
               vld2_q <= vld2_d;
               dat2_q <= dat2_d;
            end
         end

         assign out_vld = vld2_q;
         assign out_raw = dat2_q;
      end else begin : g_rl1
         assign out_vld = vld1_q;
         assign out_raw = p1_lanes;
      end

      // readdata follows the pipe on a valid pulse and holds otherwise.
      always_comb hold_d = out_vld ? unpack_data(out_raw) : hold_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) hold_q <= '0;
         else          hold_q <= hold_d;
      end

      assign rdv_o[p]   = out_vld;
      assign rdata_o[p] = hold_d;

`ifdef ONCHIP_RAM_PARITY_EN
      logic par_bad;
      always_comb begin
         par_bad = 1'b0;
         for (int l = 0; l < LANES; l++)
            par_bad = par_bad | (out_raw[l][8] != byte_parity(out_raw[l][7:0]));
      end
      assign perr_o[p] = out_vld && par_bad;
`else
      assign perr_o[p] = 1'b0;
`endif
   end

   assign s1_readdata      = rdata_o[0];
   assign s1_readdatavalid = rdv_o[0];
   assign s1_parity_err    = perr_o[0];
   assign s2_readdata      = rdata_o[1];
   assign s2_readdatavalid = rdv_o[1];
   assign s2_parity_err    = perr_o[1];

endmodule

// File: tb/tb_onchip_dp_ram_avmm.sv
// Self-checking bench for onchip_dp_ram_avmm. Two instances (read latency 1
// and 2, DEPTH=16, 5-bit address so addresses 16..31 are out of range) see
// identical stimulus. A word-array model with per-instance response queues
// predicts waitrequest, readdatavalid timing, readdata and parity_err.
module tb_onchip_dp_ram_avmm;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 16;

   logic clk;
   logic reset_n;

   logic          cs   [2];
   logic          rd   [2];
   logic          wr   [2];
   logic [3:0]    be   [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wd   [2];

   logic [DW-1:0] rdata_o [2][2];   // [instance][port]
   logic          rdv_o   [2][2];
   logic          wait_o  [2][2];
   logic          pe_o    [2][2];
   logic          done_o  [2];

   onchip_dp_ram_avmm #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
      .INIT_ON_RESET(1), .INIT_VALUE('0)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
      .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata_o[0][0]),
      .s1_readdatavalid(rdv_o[0][0]), .s1_waitrequest(wait_o[0][0]), .s1_parity_err(pe_o[0][0]),
      .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
      .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata_o[0][1]),
      .s2_readdatavalid(rdv_o[0][1]), .s2_waitrequest(wait_o[0][1]), .s2_parity_err(pe_o[0][1]),
      .init_done(done_o[0])
   );

   onchip_dp_ram_avmm #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
      .INIT_ON_RESET(1), .INIT_VALUE('0)
   ) u_dut2 (
      .clk(clk), .reset_n(reset_n),
      .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
      .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata_o[1][0]),
      .s1_readdatavalid(rdv_o[1][0]), .s1_waitrequest(wait_o[1][0]), .s1_parity_err(pe_o[1][0]),
      .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
      .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata_o[1][1]),
      .s2_readdatavalid(rdv_o[1][1]), .s2_waitrequest(wait_o[1][1]), .s2_parity_err(pe_o[1][1]),
      .init_done(done_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic          pe;
   } exp_t;

   int            n_vec = 0;
   int            n_bad = 0;
   int            cyc   = 0;    // clock edges seen
   int            edges = 0;    // edges since reset release
   logic [DW-1:0] mem_m  [DEPTH];
   logic          bad_m  [DEPTH];  // word has a corrupted parity bit
   exp_t          exq    [4][$];   // index = instance*2 + port
   logic [DW-1:0] last_m [4];

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expd);
      n_vec++;
      assert (obs === expd)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expd);
      end
   endtask

   task automatic drive(input int p, input logic c, input logic r, input logic w,
                        input logic [3:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cs[p] = c; rd[p] = r; wr[p] = w; be[p] = b; addr[p] = a; wd[p] = d;
   endtask

   task automatic idle();
      for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
   endtask

   // Called just after a falling edge with inputs already driven. Predicts
   // this cycle, advances one clock, then checks the responses.
   task automatic tick();
      logic run, s1w;
      logic w [2];
      int   a;
      #1;
      run  = (edges >= DEPTH);
      s1w  = run && cs[0] && wr[0];
      w[0] = !run;
      w[1] = !run || (s1w && cs[1] && wr[1] && (addr[0] == addr[1]));
      for (int i = 0; i < 2; i++)
         for (int p = 0; p < 2; p++)
            check($sformatf("waitrequest i%0d s%0d cyc%0d", i, p + 1, cyc), wait_o[i][p], w[p]);
      // Reads see the array as it was before this cycle's writes.
      for (int p = 0; p < 2; p++) begin
         if (cs[p] && rd[p] && !wr[p] && !w[p]) begin
            exp_t e;
            a = int'(addr[p]);
            e.data = (a < DEPTH) ? mem_m[a] : '0;
            e.pe   = (a < DEPTH) ? bad_m[a] : 1'b0;
            for (int i = 0; i < 2; i++) begin
               e.due = cyc + i + 1;
               exq[i*2 + p].push_back(e);
            end
         end
      end
      for (int p = 0; p < 2; p++) begin
         a = int'(addr[p]);
         if (cs[p] && wr[p] && !w[p] && a < DEPTH) begin
            for (int l = 0; l < 4; l++)
               if (be[p][l]) mem_m[a][8*l +: 8] = wd[p][8*l +: 8];
            if (be[p][1]) bad_m[a] = 1'b0;
         end
      end
      if (!run) begin
         mem_m[edges] = '0;
         bad_m[edges] = 1'b0;
      end
      edges++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         logic ev, epe;
         ev  = (exq[k].size() > 0) && (exq[k][0].due == cyc);
         epe = 1'b0;
         if (ev) begin
            last_m[k] = exq[k][0].data;
            epe       = exq[k][0].pe;
            void'(exq[k].pop_front());
         end
         check($sformatf("readdatavalid i%0d s%0d cyc%0d", k / 2, k % 2 + 1, cyc), rdv_o[k/2][k%2], ev);
         check($sformatf("readdata i%0d s%0d cyc%0d", k / 2, k % 2 + 1, cyc), rdata_o[k/2][k%2], last_m[k]);
         check($sformatf("parity_err i%0d s%0d cyc%0d", k / 2, k % 2 + 1, cyc), pe_o[k/2][k%2], epe);
      end
      for (int i = 0; i < 2; i++)
         check($sformatf("init_done i%0d cyc%0d", i, cyc), done_o[i], edges >= DEPTH);
   endtask

   // Asserts reset right after a falling edge, holds it for n edges and
   // releases it on a falling edge. Pending responses are dropped.
   task automatic apply_reset(input int n);
      reset_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exq[k].delete();
         last_m[k] = '0;
      end
      for (int c = 0; c <= n; c++) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            check($sformatf("rst init_done i%0d", i), done_o[i], 1'b0);
            for (int p = 0; p < 2; p++) begin
               check($sformatf("rst waitrequest i%0d s%0d", i, p + 1), wait_o[i][p], 1'b1);
               check($sformatf("rst readdatavalid i%0d s%0d", i, p + 1), rdv_o[i][p], 1'b0);
               check($sformatf("rst readdata i%0d s%0d", i, p + 1), rdata_o[i][p], '0);
               check($sformatf("rst parity_err i%0d s%0d", i, p + 1), pe_o[i][p], 1'b0);
            end
         end
         // The clear engine sits on word 0 while reset is held.
         mem_m[0] = '0;
         bad_m[0] = 1'b0;
         if (c < n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
         end
      end
      reset_n = 1'b1;
      edges   = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      for (int a = 0; a < DEPTH; a++) bad_m[a] = 1'b0;
      for (int k = 0; k < 4; k++) last_m[k] = '0;
      @(negedge clk);
      apply_reset(3);

      // Clear engine: a read held during INIT is stalled until the first
      // accept cycle.
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd2, '0);
      repeat (DEPTH + 1) tick();
      idle();

      // Sweep every word on both ports after the clear.
      for (int a = 0; a < DEPTH; a++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 4'hF, AW'(a), '0);
         drive(1, 1'b1, 1'b1, 1'b0, 4'hF, AW'(DEPTH - 1 - a), '0);
         tick();
      end
      idle();
      repeat (3) tick();

      // Byte-lane write over a full word, then read it back the next cycle.
      drive(0, 1'b1, 1'b0, 1'b1, 4'hF, 5'd3, 32'h1122_3344);
      tick();
      drive(0, 1'b1, 1'b0, 1'b1, 4'h5, 5'd3, 32'hDEAD_BEEF);
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd3, '0);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 5'd3, '0);
      tick();
      idle();
      repeat (3) tick();

      // Same-word write collision: s2 stalled once, then completes.
      drive(0, 1'b1, 1'b0, 1'b1, 4'hF, 5'd7, 32'hAAAA_0000);
      drive(1, 1'b1, 1'b0, 1'b1, 4'hF, 5'd7, 32'h0000_BBBB);
      tick();
      drive(0, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
      tick();
      idle();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd7, '0);
      tick();
      idle();
      repeat (3) tick();

      // Read on s1 while s2 writes the same word: old data, then new.
      drive(0, 1'b1, 1'b0, 1'b1, 4'hF, 5'd5, 32'h1);
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd5, '0);
      drive(1, 1'b1, 1'b0, 1'b1, 4'hF, 5'd5, 32'h2);
      tick();
      drive(1, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
      tick();
      idle();
      repeat (3) tick();

      // Out-of-range write discarded (no aliasing), out-of-range read is 0.
      drive(1, 1'b1, 1'b0, 1'b1, 4'hF, 5'd21, 32'hFFFF_FFFF);
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd21, '0);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 5'd5, '0);
      tick();
      idle();

      // read and write together: write only, no response.
      drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 5'd6, 32'h0000_600D);
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 5'd6, '0);
      tick();
      idle();
      repeat (3) tick();

`ifdef ONCHIP_RAM_PARITY_EN
      // Corrupt the stored parity of byte 1 at word 9.
      drive(0, 1'b1, 1'b0, 1'b1, 4'hF, 5'd9, 32'h0102_0304);
      tick();
      idle();
      u_dut1.u_core.mem[9][1][8] = ~u_dut1.u_core.mem[9][1][8];
      u_dut2.u_core.mem[9][1][8] = ~u_dut2.u_core.mem[9][1][8];
      bad_m[9] = 1'b1;
      for (int a = 8; a <= 10; a++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 4'hF, AW'(a), '0);
         drive(1, 1'b1, 1'b1, 1'b0, 4'hF, AW'(18 - a), '0);
         tick();
      end
      idle();
      repeat (3) tick();
`endif

      // Random traffic on both ports, biased towards a few words so
      // collisions happen, with occasional out-of-range addresses.
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? AW'(16 + $urandom_range(0, 3))
                                            : AW'($urandom_range(0, 7));
            drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
         end
         tick();
      end
      idle();
      repeat (3) tick();

      // Back-to-back s2 reads with reset pulsed mid-stream, then a second
      // reset part way through the clear.
      for (int n = 0; n < 4; n++) begin
         drive(1, 1'b1, 1'b1, 1'b0, 4'hF, AW'(n), '0);
         tick();
      end
      apply_reset(2);
      repeat (5) tick();
      apply_reset(1);
      repeat (DEPTH) tick();
      idle();
      for (int a = 0; a < DEPTH; a++) begin
         drive(1, 1'b1, 1'b1, 1'b0, 4'hF, AW'(a), '0);
         tick();
      end
      idle();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
